alarm_ctrl: RTL and testbench

Alarm controller that consumes the running BCD hour/minute time from the hour (00–23) and minute (00–59) counters. It holds a user-settable alarm time, detects when the current time reaches it, and drives a ring output. Ringing stops on a stop key or on a timeout, and can be snoozed a limited number of times. It sits downstream of the timekeeping counters and upstream of the buzzer/display drivers.

---
 rtl/alarm_pkg.sv | 21 ++
 rtl/alarm_ctrl_bcd_set_counter.sv | 31 +++
 rtl/alarm_ctrl.sv | 139 +++++++++++++
 tb/tb_alarm_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared types and limits for the alarm controller.
// State encoding, BCD wrap limits and counter widths.
package alarm_pkg;

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        ARMED  = 2'd1,
        RING   = 2'd2,
        SNOOZE = 2'd3
    } state_t;

    localparam logic [3:0] HOUR_MAX_H = 4'd2;
    localparam logic [3:0] HOUR_MAX_L = 4'd3;
    localparam logic [3:0] MIN_MAX_H  = 4'd5;
    localparam logic [3:0] MIN_MAX_L  = 4'd9;

    localparam int RING_W = 7;
    localparam int SNZ_W  = 9;
    localparam int CNT_W  = 3;

endpackage

// File: rtl/alarm_ctrl_bcd_set_counter.sv
// Two-digit BCD counter with wrap at MAX_H:MAX_L.
// Used for the user-editable alarm hour and minute.
module bcd_set_counter #(
    parameter logic [3:0] MAX_H = 4'd2,
    parameter logic [3:0] MAX_L = 4'd3
) (
    input  logic       CP,
    input  logic       nCR,
    input  logic       Inc,
    output logic [3:0] H,
    output logic [3:0] L
);

    always_ff @(posedge CP) begin
        if (!nCR) begin
            H <= 4'd0;
            L <= 4'd0;
        end else if (Inc) begin
            if (H == MAX_H && L == MAX_L) begin
                H <= 4'd0;
                L <= 4'd0;
            end else if (L == 4'd9) begin
                H <= H + 4'd1;
                L <= 4'd0;
            end else begin
                L <= L + 4'd1;
            end
        end
    end

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm controller: stored alarm time, edge-triggered match,
// ring timeout and limited snooze.
module alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300,
    parameter int MAX_SNOOZE  = 3
) (
    input  logic       CP,
    input  logic       nCR,
    input  logic       SecTick,
    input  logic [3:0] CurHH,
    input  logic [3:0] CurHL,
    input  logic [3:0] CurMH,
    input  logic [3:0] CurML,
    input  logic       AlarmOn,
    input  logic       SetMode,
    input  logic       IncHour,
    input  logic       IncMin,
    input  logic       StopKey,
    input  logic       SnoozeKey,
    output logic [3:0] AlmHH,
    output logic [3:0] AlmHL,
    output logic [3:0] AlmMH,
    output logic [3:0] AlmML,
    output logic       Ring,
    output logic       Snoozing
);

    state_t            st_q, st_d;
    logic [RING_W-1:0] ring_q, ring_d;
    logic [SNZ_W-1:0]  snz_q, snz_d;
    logic [CNT_W-1:0]  num_q, num_d;
    logic              matchq, matchprev;
    logic              match, trigger;

    bcd_set_counter #(
        .MAX_H(HOUR_MAX_H),
        .MAX_L(HOUR_MAX_L)
    ) u_hour (
        .CP (CP),
        .nCR(nCR),
        .Inc(IncHour & SetMode),
        .H  (AlmHH),
        .L  (AlmHL)
    );

    bcd_set_counter #(
        .MAX_H(MIN_MAX_H),
        .MAX_L(MIN_MAX_L)
    ) u_min (
        .CP (CP),
        .nCR(nCR),
        .Inc(IncMin & SetMode),
        .H  (AlmMH),
        .L  (AlmML)
    );

    assign match = ({CurHH, CurHL, CurMH, CurML}
                    == {AlmHH, AlmHL, AlmMH, AlmML});

    // Edge of the match, so a held minute cannot retrigger.
    assign trigger = matchq & ~matchprev & ~SetMode;

    always_ff @(posedge CP) begin
        if (!nCR) begin
            st_q      <= OFF;
            ring_q    <= '0;
            snz_q     <= '0;
            num_q     <= '0;
            matchq    <= 1'b0;
            matchprev <= 1'b0;
        end else begin
            st_q      <= st_d;
            ring_q    <= ring_d;
            snz_q     <= snz_d;
            num_q     <= num_d;
            matchq    <= match;
            matchprev <= matchq;
        end
    end

    always_comb begin
        st_d   = st_q;
        ring_d = ring_q;
        snz_d  = snz_q;
        num_d  = num_q;
        if (!AlarmOn) begin
            st_d = OFF;
        end else begin
            unique case (st_q)
                OFF: st_d = ARMED;
                ARMED: begin
                    if (trigger) begin
                        st_d   = RING;
                        ring_d = '0;
                        num_d  = '0;
                    end
                end
                RING: begin
                    if (StopKey) begin
                        st_d = ARMED;
                    end else if (SnoozeKey) begin
                        if (num_q < CNT_W'(MAX_SNOOZE)) begin
                            st_d  = SNOOZE;
                            num_d = num_q + 1'b1;
                            snz_d = '0;
                        end else begin
                            st_d = ARMED;
                        end
                    end else if (SecTick) begin
                        if (ring_q == RING_W'(RING_SECS - 1))
                            st_d = ARMED;
                        else
                            ring_d = ring_q + 1'b1;
                    end
                end
                SNOOZE: begin
                    if (StopKey) begin
                        st_d = ARMED;
                    end else if (SecTick) begin
                        if (snz_q == SNZ_W'(SNOOZE_SECS - 1)) begin
                            st_d   = RING;
                            ring_d = '0;
                        end else begin
                            snz_d = snz_q + 1'b1;
                        end
                    end
                end
                default: st_d = OFF;
            endcase
        end
    end

    assign Ring     = (st_q == RING);
    assign Snoozing = (st_q == SNOOZE);

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed bench for alarm_ctrl with a per-cycle reference model
// and literal spot checks.
module tb_alarm_ctrl;

    localparam int RS = 60;
    localparam int SS = 300;
    localparam int MS = 3;

    logic       CP = 1'b0;
    logic       nCR = 1'b0;
    logic       SecTick = 1'b0;
    logic [3:0] CurHH = 4'd1, CurHL = 4'd2, CurMH = 4'd0, CurML = 4'd0;
    logic       AlarmOn = 1'b0, SetMode = 1'b0;
    logic       IncHour = 1'b0, IncMin = 1'b0;
    logic       StopKey = 1'b0, SnoozeKey = 1'b0;
    logic [3:0] AlmHH, AlmHL, AlmMH, AlmML;
    logic       Ring, Snoozing;

    alarm_ctrl #(
        .RING_SECS  (RS),
        .SNOOZE_SECS(SS),
        .MAX_SNOOZE (MS)
    ) dut (
        .CP       (CP),
        .nCR      (nCR),
        .SecTick  (SecTick),
        .CurHH    (CurHH),
        .CurHL    (CurHL),
        .CurMH    (CurMH),
        .CurML    (CurML),
        .AlarmOn  (AlarmOn),
        .SetMode  (SetMode),
        .IncHour  (IncHour),
        .IncMin   (IncMin),
        .StopKey  (StopKey),
        .SnoozeKey(SnoozeKey),
        .AlmHH    (AlmHH),
        .AlmHL    (AlmHL),
        .AlmMH    (AlmMH),
        .AlmML    (AlmML),
        .Ring     (Ring),
        .Snoozing (Snoozing)
    );

    always #5 CP = ~CP;

    int total = 0;
    int passed = 0;
    bit checking = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Model: alarm as integer hour/minute, mode as 0..3, elapsed seconds.
    localparam int M_OFF = 0, M_ARM = 1, M_RING = 2, M_SNZ = 3;
    int  m_mode = M_OFF;
    int  a_h = 0, a_m = 0;
    int  ring_s = 0, snz_s = 0, n_snz = 0;
    bit  seen = 0, seen_prev = 0;

    always @(posedge CP) begin
        bit now_match, edge_hit;
        if (!nCR) begin
            m_mode = M_OFF;
            a_h = 0; a_m = 0;
            ring_s = 0; snz_s = 0; n_snz = 0;
            seen = 0; seen_prev = 0;
        end else begin
            edge_hit  = seen && !seen_prev && !SetMode;
            now_match = (int'(CurHH) == a_h / 10) && (int'(CurHL) == a_h % 10)
                     && (int'(CurMH) == a_m / 10) && (int'(CurML) == a_m % 10);
            if (SetMode) begin
                if (IncHour) a_h = (a_h + 1) % 24;
                if (IncMin)  a_m = (a_m + 1) % 60;
            end
            if (!AlarmOn) m_mode = M_OFF;
            else if (m_mode == M_OFF) m_mode = M_ARM;
            else if (m_mode == M_ARM) begin
                if (edge_hit) begin
                    m_mode = M_RING; ring_s = 0; n_snz = 0;
                end
            end else if (m_mode == M_RING) begin
                if (StopKey) m_mode = M_ARM;
                else if (SnoozeKey) begin
                    if (n_snz < MS) begin
                        m_mode = M_SNZ; n_snz++; snz_s = 0;
                    end else m_mode = M_ARM;
                end else if (SecTick) begin
                    ring_s++;
                    if (ring_s >= RS) m_mode = M_ARM;
                end
            end else begin
                if (StopKey) m_mode = M_ARM;
                else if (SecTick) begin
                    snz_s++;
                    if (snz_s >= SS) begin
                        m_mode = M_RING; ring_s = 0;
                    end
                end
            end
            seen_prev = seen;
            seen = now_match;
        end
    end

    always @(negedge CP) begin
        logic [17:0] exp;
        if (checking) begin
            exp = {4'(a_h / 10), 4'(a_h % 10), 4'(a_m / 10), 4'(a_m % 10),
                   m_mode == M_RING, m_mode == M_SNZ};
            chk("cycle", 32'({AlmHH, AlmHL, AlmMH, AlmML, Ring, Snoozing}),
                32'(exp));
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge CP);
    endtask

    task automatic set_time(input int h, input int m);
        CurHH = 4'(h / 10); CurHL = 4'(h % 10);
        CurMH = 4'(m / 10); CurML = 4'(m % 10);
    endtask

    task automatic inc_hour(input int n);
        repeat (n) begin
            IncHour = 1'b1; @(negedge CP); IncHour = 1'b0;
        end
    endtask

    task automatic inc_min(input int n);
        repeat (n) begin
            IncMin = 1'b1; @(negedge CP); IncMin = 1'b0;
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            SecTick = 1'b1; @(negedge CP); SecTick = 1'b0;
            @(negedge CP);
        end
    endtask

    task automatic stop_key();
        StopKey = 1'b1; @(negedge CP); StopKey = 1'b0;
    endtask

    task automatic snooze_key();
        SnoozeKey = 1'b1; @(negedge CP); SnoozeKey = 1'b0;
    endtask

    task automatic retrigger(input int h, input int m);
        set_time(h, m + 1);
        idle(3);
        set_time(h, m);
        idle(2);
    endtask

    initial begin
        idle(3);
        nCR = 1'b1;
        checking = 1;
        chk("reset_time", 32'({AlmHH, AlmHL, AlmMH, AlmML}), 32'h0000);
        chk("reset_out", 32'({Ring, Snoozing}), 32'd0);

        SetMode = 1'b1;
        inc_hour(7);
        inc_min(30);
        SetMode = 1'b0;
        idle(1);
        chk("set_0730", 32'({AlmHH, AlmHL, AlmMH, AlmML}), 32'h0730);
        SetMode = 1'b1;
        inc_hour(17);
        idle(1);
        chk("hour_wrap", 32'({AlmHH, AlmHL, AlmMH, AlmML}), 32'h0030);
        inc_hour(7);
        SetMode = 1'b0;
        inc_hour(2);
        chk("inc_ignored", 32'({AlmHH, AlmHL, AlmMH, AlmML}), 32'h0730);

        AlarmOn = 1'b1;
        set_time(7, 29);
        idle(4);
        set_time(7, 30);
        idle(1);
        chk("ring_lat1", 32'(Ring), 32'd0);
        idle(1);
        chk("ring_lat2", 32'(Ring), 32'd1);
        stop_key();
        chk("stop", 32'(Ring), 32'd0);
        ticks(5);
        idle(10);
        chk("no_retrig", 32'(Ring), 32'd0);

        retrigger(7, 30);
        chk("ring2", 32'(Ring), 32'd1);
        ticks(RS - 1);
        chk("ring_59", 32'(Ring), 32'd1);
        ticks(1);
        chk("ring_timeout", 32'(Ring), 32'd0);

        retrigger(7, 30);
        chk("ring3", 32'(Ring), 32'd1);
        for (int i = 0; i < MS; i++) begin
            snooze_key();
            chk("snooze_on", 32'({Ring, Snoozing}), 32'b01);
            ticks(SS - 1);
            chk("snooze_hold", 32'({Ring, Snoozing}), 32'b01);
            ticks(1);
            chk("snooze_end", 32'({Ring, Snoozing}), 32'b10);
        end
        snooze_key();
        chk("snooze_limit", 32'({Ring, Snoozing}), 32'b00);

        set_time(8, 30);
        idle(2);
        SetMode = 1'b1;
        inc_hour(1);
        idle(4);
        SetMode = 1'b0;
        idle(5);
        chk("setmode_exit", 32'(Ring), 32'd0);

        retrigger(8, 30);
        chk("ring4", 32'(Ring), 32'd1);
        AlarmOn = 1'b0;
        idle(1);
        chk("alarm_off", 32'(Ring), 32'd0);
        AlarmOn = 1'b1;
        idle(3);

        retrigger(8, 30);
        chk("ring5", 32'(Ring), 32'd1);
        nCR = 1'b0;
        #1;
        chk("pre_reset", 32'(Ring), 32'd1);
        idle(1);
        chk("reset_ring", 32'({AlmHH, AlmHL, AlmMH, AlmML, Ring, Snoozing}),
            32'd0);
        nCR = 1'b1;
        idle(3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
